// File: rtl/vae_pkg.sv
// Shared VAE encoder definitions: MAC sequencing states, Q-format constants
// and the lane saturation helper used by the encoder datapath blocks.
package vae_pkg;

   localparam int Q_LANE_W = 16;
   localparam int Q_FRAC   = 8;

   localparam logic signed [63:0] SAT_MAX = (64'sd1 <<< (Q_LANE_W - 1)) - 64'sd1;
   localparam logic signed [63:0] SAT_MIN = -(64'sd1 <<< (Q_LANE_W - 1));

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACC,
      ST_DRAIN,
      ST_FINAL,
      ST_OUT
   } state_e;

   // Clamp a wide signed value into the signed Q lane range.
   function automatic logic signed [Q_LANE_W-1:0] saturate(input logic signed [63:0] v);
      if (v > SAT_MAX) begin
         return Q_LANE_W'(SAT_MAX);
      end else if (v < SAT_MIN) begin
         return Q_LANE_W'(SAT_MIN);
      end
      return v[Q_LANE_W-1:0];
   endfunction

endpackage

// File: rtl/vae_mac_tree.sv
// Unpacks every channel word into {x,w} lane pairs, multiplies them and sums
// all products of one beat; the sum is registered as the first pipeline stage.
module vae_mac_tree #(
   parameter int NUM_CH = 4,
   parameter int DMA_W  = 64,
   parameter int LANE_W = 16,
   parameter int ACC_W  = 40
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     valid_i,
   input  logic [NUM_CH*DMA_W-1:0]  data_i,
   output logic                     valid_o,
   output logic signed [ACC_W-1:0]  sum_o
);

   localparam int P = DMA_W / (2 * LANE_W);

   logic signed [LANE_W-1:0]   x;
   logic signed [LANE_W-1:0]   w;
   logic signed [2*LANE_W-1:0] prod;
   logic signed [ACC_W-1:0]    sumComb;

   always_comb begin
      x       = '0;
      w       = '0;
      prod    = '0;
      sumComb = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         for (int k = 0; k < P; k++) begin
            x       = $signed(data_i[c*DMA_W + 2*k*LANE_W +: LANE_W]);
            w       = $signed(data_i[c*DMA_W + (2*k+1)*LANE_W +: LANE_W]);
            prod    = x * w;
            sumComb = sumComb + $signed({{(ACC_W-2*LANE_W){prod[2*LANE_W-1]}}, prod});
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_o <= 1'b0;
         sum_o   <= '0;
      end else begin
         valid_o <= valid_i;
         if (valid_i) begin
            sum_o <= sumComb;
         end
      end
   end

endmodule

// File: rtl/vae_latent_mac.sv
// Multi-channel latent MAC: accumulates a runtime number of DMA beats, adds a
// bias, saturates to a Q lane value and optionally pairs mu with logvar.
module vae_latent_mac
   import vae_pkg::*;
#(
   parameter int  NUM_CH    = 4,
   parameter int  DMA_W     = 64,
   parameter int  LANE_W    = Q_LANE_W,
   parameter int  FRAC      = Q_FRAC,
   parameter int  ACC_W     = 40,
   parameter int  MAX_BEATS = 64,
   localparam int BEAT_W    = $clog2(MAX_BEATS + 1)
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     clr_i,
   input  logic                     start_i,
   input  logic                     op_mode_i,
   input  logic                     pair_en_i,
   input  logic [BEAT_W-1:0]        beats_i,
   input  logic [LANE_W-1:0]        bias_i,
   input  logic [NUM_CH*DMA_W-1:0]  dma_data_i,
   input  logic                     in_valid_i,
   output logic                     in_ready_o,
   output logic [LANE_W-1:0]        result_o,
   output logic                     done_o,
   output logic                     busy_o
);

   state_e state_q, state_d;

   logic                     opMode_q, pairEn_q;
   logic [BEAT_W-1:0]        beatsCfg_q, count_q;
   logic [LANE_W-1:0]        bias_q;
   logic signed [ACC_W-1:0]  acc_q;
   logic signed [LANE_W-1:0] hold_q, r_q;
   logic                     holdValid_q;
   logic [LANE_W-1:0]        result_q;
   logic                     done_q;

   logic                     accept;
   logic                     sumValid;
   logic signed [ACC_W-1:0]  beatSum;
   logic signed [ACC_W-1:0]  biasScaled, biased, shifted;
   logic signed [LANE_W-1:0] rPlain, rPaired, rFinal;

   assign in_ready_o = (state_q == ST_ACC);
   assign busy_o     = (state_q != ST_IDLE);
   assign result_o   = result_q;
   assign done_o     = done_q;
   assign accept     = in_valid_i & in_ready_o & ~clr_i;

   vae_mac_tree #(
      .NUM_CH (NUM_CH),
      .DMA_W  (DMA_W),
      .LANE_W (LANE_W),
      .ACC_W  (ACC_W)
   ) u_tree (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .valid_i (accept),
      .data_i  (dma_data_i),
      .valid_o (sumValid),
      .sum_o   (beatSum)
   );

   // Bias is aligned to the accumulator's 2*FRAC scale before dropping FRAC bits.
   assign biasScaled = $signed({{(ACC_W-LANE_W){bias_q[LANE_W-1]}}, bias_q}) <<< FRAC;
   assign biased     = acc_q + biasScaled;
   assign shifted    = biased >>> FRAC;
   assign rPlain     = saturate($signed({{(64-ACC_W){shifted[ACC_W-1]}}, shifted}));
   assign rPaired    = saturate($signed({{(64-LANE_W){rPlain[LANE_W-1]}}, rPlain})
                              + $signed({{(64-LANE_W){hold_q[LANE_W-1]}}, hold_q}));
   assign rFinal     = (opMode_q && holdValid_q) ? rPaired : rPlain;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start_i) state_d = ST_ACC;
         ST_ACC:   if (accept && (count_q + BEAT_W'(1)) == beatsCfg_q) state_d = ST_DRAIN;
         ST_DRAIN: state_d = ST_FINAL;
         ST_FINAL: state_d = ST_OUT;
         ST_OUT:   state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      if (clr_i) begin
         state_d = ST_IDLE;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         opMode_q    <= 1'b0;
         pairEn_q    <= 1'b0;
         beatsCfg_q  <= '0;
         bias_q      <= '0;
         count_q     <= '0;
         acc_q       <= '0;
         hold_q      <= '0;
         holdValid_q <= 1'b0;
         r_q         <= '0;
         result_q    <= '0;
         done_q      <= 1'b0;
      end else if (clr_i) begin
         count_q     <= '0;
         acc_q       <= '0;
         hold_q      <= '0;
         holdValid_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (state_q == ST_IDLE && start_i) begin
            opMode_q   <= op_mode_i;
            pairEn_q   <= pair_en_i;
            beatsCfg_q <= (beats_i == '0) ? BEAT_W'(1) : beats_i;
            bias_q     <= bias_i;
            count_q    <= '0;
            acc_q      <= '0;
         end
         // Stale tree output after an abort arrives in IDLE and is dropped here.
         if (sumValid && (state_q == ST_ACC || state_q == ST_DRAIN)) begin
            acc_q <= acc_q + beatSum;
         end
         if (accept) begin
            count_q <= count_q + BEAT_W'(1);
         end
         if (state_q == ST_FINAL) begin
            r_q <= rFinal;
            if (opMode_q && holdValid_q) begin
               holdValid_q <= 1'b0;
            end else if (!opMode_q && pairEn_q) begin
               hold_q      <= rPlain;
               holdValid_q <= 1'b1;
            end
         end
         if (state_q == ST_OUT) begin
            result_q <= r_q;
            done_q   <= 1'b1;
            acc_q    <= '0;
         end
      end
   end

endmodule

// File: tb/tb_vae_latent_mac.sv
// Randomised bench for vae_latent_mac: a 4-channel and a 2-channel instance run
// in lockstep against an arithmetic reference model of the MAC operation.
module tb_vae_latent_mac;

   localparam int NCH    = 4;
   localparam int DMA_W  = 64;
   localparam int LANE_W = 16;
   localparam int BEAT_W = 7;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic                   clr, start, opMode, pairEn, inValid;
   logic [BEAT_W-1:0]      beats;
   logic [LANE_W-1:0]      bias;
   logic [NCH*DMA_W-1:0]   dmaData;
   logic                   inReady, done, busy;
   logic [LANE_W-1:0]      result;
   logic                   inReady2, done2, busy2;
   logic [LANE_W-1:0]      result2;

   int checks = 0;
   int errors = 0;

   logic [NCH*DMA_W-1:0] beatQ[$];
   int                   holdVal[2];
   bit                   holdValid[2];
   logic [LANE_W-1:0]    lastResult[2];

   always #5 clk = ~clk;

   vae_latent_mac dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .clr_i      (clr),
      .start_i    (start),
      .op_mode_i  (opMode),
      .pair_en_i  (pairEn),
      .beats_i    (beats),
      .bias_i     (bias),
      .dma_data_i (dmaData),
      .in_valid_i (inValid),
      .in_ready_o (inReady),
      .result_o   (result),
      .done_o     (done),
      .busy_o     (busy)
   );

   vae_latent_mac #(.NUM_CH(2)) dut2 (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .clr_i      (clr),
      .start_i    (start),
      .op_mode_i  (opMode),
      .pair_en_i  (pairEn),
      .beats_i    (beats),
      .bias_i     (bias),
      .dma_data_i (dmaData[2*DMA_W-1:0]),
      .in_valid_i (inValid),
      .in_ready_o (inReady2),
      .result_o   (result2),
      .done_o     (done2),
      .busy_o     (busy2)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   function automatic int satLane(input longint v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return int'(v);
   endfunction

   // Reference: plain dot product over the accepted beats, floor-scaled, clamped, paired.
   function automatic logic [LANE_W-1:0] refOp(input int inst, input bit opM, input bit pe, input logic [LANE_W-1:0] b);
      int                   nch = (inst == 0) ? 4 : 2;
      longint               acc = 0;
      longint               t;
      int                   r;
      logic [NCH*DMA_W-1:0] word;
      shortint              x, w;
      foreach (beatQ[i]) begin
         word = beatQ[i];
         for (int c = 0; c < nch; c++) begin
            for (int k = 0; k < 2; k++) begin
               x = $signed(word[c*64 + 32*k +: 16]);
               w = $signed(word[c*64 + 32*k + 16 +: 16]);
               acc += longint'(x) * longint'(w);
            end
         end
      end
      t = (acc + longint'($signed(b)) * 256) >>> 8;
      r = satLane(t);
      if (opM && holdValid[inst]) begin
         r = satLane(longint'(r) + longint'(holdVal[inst]));
         holdValid[inst] = 1'b0;
      end else if (!opM && pe) begin
         holdVal[inst]   = r;
         holdValid[inst] = 1'b1;
      end
      lastResult[inst] = 16'(r);
      return 16'(r);
   endfunction

   function automatic logic [NCH*DMA_W-1:0] makeWord(input int mode);
      logic [NCH*DMA_W-1:0] word;
      logic [15:0]          v;
      word = '0;
      for (int l = 0; l < NCH*DMA_W/16; l++) begin
         case (mode)
            0:       v = 16'h0100;
            1:       v = 16'h7FFF;
            2:       v = (l % 2 == 0) ? 16'h8000 : 16'h7FFF;
            3:       v = 16'($urandom);
            default: v = 16'($urandom_range(0, 1023) - 512);
         endcase
         word[l*16 +: 16] = v;
      end
      return word;
   endfunction

   function automatic void clearModel();
      for (int i = 0; i < 2; i++) begin
         holdValid[i] = 1'b0;
         holdVal[i]   = 0;
      end
   endfunction

   // One complete operation; validMode 0=always, 1=alternating, 2=random.
   task automatic applyStimulus(input bit opM, input bit pe, input int nBeats, input logic [LANE_W-1:0] b,
                                input int dataMode, input int validMode, input bit startMid);
      int eff = (nBeats == 0) ? 1 : nBeats;
      int got = 0;
      int cyc = 0;
      int edges = 0;
      logic [LANE_W-1:0] exp0, exp1;
      beatQ.delete();
      @(negedge clk);
      opMode = opM; pairEn = pe; beats = BEAT_W'(nBeats); bias = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (got < eff && cyc < 1000) begin
         case (validMode)
            0:       inValid = 1'b1;
            1:       inValid = (cyc % 2 == 0);
            default: inValid = 1'($urandom_range(0, 1));
         endcase
         dmaData = makeWord(dataMode);
         if (startMid && got == 1) begin
            start = 1'b1; beats = 7'd1; bias = ~b; opMode = ~opM;
         end else begin
            start = 1'b0;
         end
         if (inValid && inReady) begin
            beatQ.push_back(dmaData);
            got++;
         end
         cyc++;
         @(negedge clk);
      end
      inValid = 1'b0;
      start   = 1'b0;
      checkOutput("beats_accepted", got, eff);
      checkOutput("in_ready_drop", inReady, 0);
      exp0 = refOp(0, opM, pe, b);
      exp1 = refOp(1, opM, pe, b);
      while (!done && edges < 10) begin
         @(negedge clk);
         edges++;
      end
      checkOutput("done_latency", edges, 3);
      checkOutput("result", result, exp0);
      checkOutput("result_nch2", result2, exp1);
      checkOutput("done_nch2", done2, 1);
      checkOutput("busy_at_done", busy, 0);
      @(negedge clk);
      checkOutput("done_one_cycle", done, 0);
   endtask

   initial begin
      int sawDone;
      rst_n = 1'b0; clr = 1'b0; start = 1'b0; opMode = 1'b0; pairEn = 1'b0;
      inValid = 1'b0; beats = '0; bias = '0; dmaData = '0;
      clearModel();
      lastResult[0] = '0;
      lastResult[1] = '0;
      #12;
      checkOutput("reset_result", result, 0);
      checkOutput("reset_done", done, 0);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_in_ready", inReady, 0);
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus(0, 0, 8, 16'h0000, 0, 0, 0);
      checkOutput("basic_const", result, 16'h4000);
      checkOutput("basic_nch2_const", result2, 16'h2000);
      applyStimulus(0, 1, 8, 16'hFC9C, 0, 0, 0);
      checkOutput("mu_const", result, 16'h3C9C);
      applyStimulus(1, 0, 8, 16'hFFF2, 0, 0, 0);
      checkOutput("logvar_pair_const", result, 16'h7C8E);
      applyStimulus(0, 0, 8, 16'h0000, 1, 0, 0);
      checkOutput("sat_pos_const", result, 16'h7FFF);
      applyStimulus(0, 0, 8, 16'h0000, 2, 0, 0);
      checkOutput("sat_neg_const", result, 16'h8000);
      applyStimulus(0, 0, 3, 16'h0000, 0, 1, 0);

      // Abort after four beats, with a beat offered alongside clr.
      applyStimulus(0, 1, 2, 16'h0040, 4, 0, 0);
      @(negedge clk);
      opMode = 1'b0; pairEn = 1'b0; beats = 7'd8; bias = '0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) begin
         inValid = 1'b1;
         dmaData = makeWord(0);
         @(negedge clk);
      end
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      inValid = 1'b0;
      clearModel();
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_in_ready", inReady, 0);
      checkOutput("abort_result_held", result, lastResult[0]);
      sawDone = 0;
      repeat (6) begin
         @(negedge clk);
         if (done) sawDone = 1;
      end
      checkOutput("abort_no_done", sawDone, 0);
      applyStimulus(1, 0, 8, 16'h0000, 0, 0, 0);
      checkOutput("after_abort_const", result, 16'h4000);

      applyStimulus(0, 0, 0, 16'h0000, 0, 2, 0);
      checkOutput("beats0_const", result, 16'h0800);
      applyStimulus(0, 0, 6, 16'h0010, 4, 2, 1);

      for (int i = 0; i < 24; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 20)),
                       16'($urandom), int'($urandom_range(3, 4)), int'($urandom_range(0, 2)),
                       1'($urandom_range(0, 1)));
      end

      // Asynchronous reset in the middle of accumulation.
      @(negedge clk);
      opMode = 1'b0; pairEn = 1'b1; beats = 7'd8; bias = '0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) begin
         inValid = 1'b1;
         dmaData = makeWord(0);
         @(negedge clk);
      end
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rst_mid_result", result, 0);
      checkOutput("rst_mid_result_nch2", result2, 0);
      checkOutput("rst_mid_done", done, 0);
      checkOutput("rst_mid_busy", busy, 0);
      checkOutput("rst_mid_in_ready", inReady, 0);
      inValid = 1'b0;
      clearModel();
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(1, 0, 4, 16'h0100, 4, 2, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
